string_arbiter: RTL

STRING_ARBITER -- requirements
Module: string_arbiter

---
 rtl/string_pkg.sv | 23 ++
 rtl/string_fsm.sv | 32 +++
 rtl/string_arbiter.sv | 112 +++++++++++
 3 files changed

// File: rtl/string_pkg.sv
// Shared constants and state types for the string arbiter and its recognizer.
package string_pkg;

    localparam logic [7:0] CHAR_ZERO = 8'd48;
    localparam logic [7:0] CHAR_NINE = 8'd57;
    localparam logic [7:0] CHAR_STAR = 8'd42;
    localparam logic [7:0] CHAR_PLUS = 8'd43;

    localparam int         TIMEOUT_LIMIT = 16;
    localparam logic [3:0] TIMEOUT_LAST  = 4'(TIMEOUT_LIMIT - 1);

    typedef enum logic [1:0] {START, ACC, OP, ERR} rec_state_t;
    typedef enum logic [1:0] {IDLE, BUSY, REPORT} arb_state_t;

    function automatic logic isDigit(input logic [7:0] c);
        return (c >= CHAR_ZERO) && (c <= CHAR_NINE);
    endfunction

    function automatic logic isOp(input logic [7:0] c);
        return (c == CHAR_STAR) || (c == CHAR_PLUS);
    endfunction

endpackage

// File: rtl/string_fsm.sv
// Recognizer for strings of the form digit (op digit)*, stepped one character per handshake.
module string_fsm
    import string_pkg::*;
(
    input  logic       clk,
    input  logic       clr_n,
    input  logic       step,
    input  logic       restart,
    input  logic [7:0] char,
    output logic       accept
);

    rec_state_t r_state;

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_state <= START;
        end else if (restart) begin
            r_state <= START;
        end else if (step) begin
            case (r_state)
                START:   r_state <= isDigit(char) ? ACC : ERR;
                ACC:     r_state <= isOp(char)    ? OP  : ERR;
                OP:      r_state <= isDigit(char) ? ACC : ERR;
                default: r_state <= ERR;
            endcase
        end
    end

    assign accept = (r_state == ACC);

endmodule

// File: rtl/string_arbiter.sv
// Round-robin arbiter feeding two character streams through one recognizer.
// Optional stall timeout enabled by defining STRING_ARB_TIMEOUT_EN.
module string_arbiter
    import string_pkg::*;
(
    input  logic       clk,
    input  logic       clr_n,
    input  logic       in0_valid,
    input  logic       in1_valid,
    input  logic [7:0] in0_data,
    input  logic [7:0] in1_data,
    input  logic       in0_last,
    input  logic       in1_last,
    output logic       in0_ready,
    output logic       in1_ready,
    output logic       res_valid,
    input  logic       res_ready,
    output logic       res_ok,
    output logic       res_id,
    output logic       res_timeout,
    output logic       busy
);

    arb_state_t r_state;
    logic       r_grant;
    logic       r_rrPtr;

    logic       w_selValid;
    logic [7:0] w_selData;
    logic       w_selLast;
    logic       w_hs;
    logic       w_resDone;
    logic       w_pick;
    logic       w_accept;
    logic       w_stallExpire;
    logic       w_timedOut;

    assign w_selValid = r_grant ? in1_valid : in0_valid;
    assign w_selData  = r_grant ? in1_data  : in0_data;
    assign w_selLast  = r_grant ? in1_last  : in0_last;
    assign w_hs       = (r_state == BUSY) && w_selValid;
    assign w_resDone  = (r_state == REPORT) && res_ready;
    // r_rrPtr names the requester that wins a tie
    assign w_pick     = (in0_valid && in1_valid) ? r_rrPtr : in1_valid;

`ifdef STRING_ARB_TIMEOUT_EN
    logic [3:0] r_stallCnt;
    logic       r_timeout;

    assign w_stallExpire = (r_state == BUSY) && !w_selValid && (r_stallCnt == TIMEOUT_LAST);

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_stallCnt <= 4'd0;
            r_timeout  <= 1'b0;
        end else begin
            if ((r_state != BUSY) || w_selValid) r_stallCnt <= 4'd0;
            else                                 r_stallCnt <= r_stallCnt + 4'd1;
            if (w_stallExpire)  r_timeout <= 1'b1;
            else if (w_resDone) r_timeout <= 1'b0;
        end
    end

    assign w_timedOut = r_timeout;
`else
    assign w_stallExpire = 1'b0;
    assign w_timedOut    = 1'b0;
`endif

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_state <= IDLE;
            r_grant <= 1'b0;
            r_rrPtr <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in0_valid || in1_valid) begin
                        r_grant <= w_pick;
                        r_rrPtr <= ~w_pick;
                        r_state <= BUSY;
                    end
                end
                BUSY: begin
                    if ((w_hs && w_selLast) || w_stallExpire) r_state <= REPORT;
                end
                REPORT: begin
                    if (res_ready) r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    string_fsm u_fsm (
        .clk     (clk),
        .clr_n   (clr_n),
        .step    (w_hs),
        .restart (w_resDone),
        .char    (w_selData),
        .accept  (w_accept)
    );

    assign in0_ready   = (r_state == BUSY) && !r_grant;
    assign in1_ready   = (r_state == BUSY) &&  r_grant;
    assign res_valid   = (r_state == REPORT);
    assign res_ok      = res_valid && w_accept && !w_timedOut;
    assign res_id      = res_valid && r_grant;
    assign res_timeout = res_valid && w_timedOut;
    assign busy        = (r_state != IDLE);

endmodule
